cpu_state_sequencer: RTL and testbench
======================================

Name: cpu_state_sequencer

Overview:
- Multicycle state generator for the Avalon-bus MIPS core.
- Produces the 4-bit `state` code consumed by the control unit: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2.
- Sits between the memory-interface handshake (`waitrequest`) and the control unit.
  - Holds a state while an Avalon access is stalled.
  - Detects halt on a jump to address 0, enforces a stall watchdog, and counts retired instructions.

Parameters:
- STALL_LIMIT, 1024: max consecutive stalled cycles before timeout; 0 disables the watchdog.
- COUNT_W, 32: width of all counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  control-unit read request for the current state
- mem_write  in  1  control-unit write request for the current state
- waitrequest  in  1  Avalon waitrequest from memory
- pc_next  in  32  PC value to be loaded at end of EXEC2
- state  out  4  current state code, registered
- active  out  1  high when state != HALT
- stalled  out  1  high in any cycle where the state is held due to waitrequest
- instr_count  out  COUNT_W  retired instruction count
- timeout  out  1  sticky; watchdog expiry caused the halt
- cycle_count  out  COUNT_W  active cycles (see Optional Feature)
- stall_count  out  COUNT_W  stalled cycles (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, `clk`. `reset` is synchronous and active-high; it overrides everything.
- Reset values: state=1 (FETCH), active=1, stalled follows the combinational rule below, instr_count=0, timeout=0, cycle_count=0, stall_count=0, stall timer=0.
- `state` is a register. `active` is decoded from `state`.
- `stalled` is combinational from state and the inputs, with no added latency:
  - FETCH: waitrequest.
  - EXEC1: mem_read & waitrequest.
  - EXEC2: mem_write & waitrequest.
  - All other states: 0.
- Transitions, one per clock edge:
  - HALT: remain until reset. All inputs are ignored and counters freeze.
  - FETCH: if waitrequest, hold; else go to DECODE. FETCH is always a read, so mem_read is not examined.
  - DECODE: go to EXEC1 unconditionally; a single cycle.
  - EXEC1: if mem_read & waitrequest, hold; else go to EXEC2.
  - EXEC2: if mem_write & waitrequest, hold. Otherwise instr_count increments, then:
    - if pc_next == 32'h0000_0000, go to HALT;
    - else go to FETCH.
  - Codes 5..15 (unreachable): go to HALT next cycle; timeout unchanged.
- Minimum instruction latency is 4 cycles (FETCH→DECODE→EXEC1→EXEC2). Each stalled cycle adds 1.
- Watchdog (STALL_LIMIT > 0):
  - The stall timer increments on each stalled cycle and clears on any non-stalled cycle.
  - When the timer reaches STALL_LIMIT while still stalled, go to HALT and set timeout=1.
  - Example: STALL_LIMIT=4 means the 5th consecutive stalled cycle enters HALT.
- Watchdog and halt priority: timeout takes priority over a normal transition in the same cycle. The EXEC2 halt-on-zero path does not set timeout.
- Counter wrap: counters wrap modulo 2^COUNT_W, with no saturation.
- Reset mid-operation: from any state, including a stalled EXEC1/EXEC2 or HALT, the next state is FETCH and all counters and timeout clear. An in-flight Avalon access is abandoned; memory must tolerate this.
- Input stability: mem_read and mem_write must be stable within a state. The sequencer samples them every cycle and does not latch them.

Optional Feature:
- Macro: SEQ_PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every cycle that state != HALT.
  - stall_count increments every cycle that stalled=1.
  - Both are cleared by reset and frozen in HALT.
- Undefined: cycle_count and stall_count are tied to 0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- No-stall run: reset, waitrequest=0, pc_next=0x1000 → state sequence 1,2,3,4,1,...; instr_count=1 after the first EXEC2 exit; stalled=0 throughout.
- Fetch stall: waitrequest=1 for 3 cycles in FETCH → state holds 1 for 3 extra cycles, stalled=1 on each; DECODE on the first cycle with waitrequest=0; with the macro, stall_count=3.
- lw stall: opcode lw, mem_read=1 in EXEC1, waitrequest=1 for 2 cycles → EXEC1 lasts 3 cycles; a write-only instruction (mem_write=1) in EXEC1 with waitrequest=1 → no hold.
- Halt on zero: pc_next=0 in EXEC2, mem_write=0 → state=0 next cycle, active=0, instr_count incremented once, timeout=0; state stays 0 for 10 further cycles.
- Watchdog: STALL_LIMIT=4, waitrequest held high in FETCH → 5th stalled cycle leads to HALT, timeout=1; then reset → state=1, timeout=0, counters 0.
- Reset mid-stall: reset asserted during a stalled EXEC2 → next cycle state=1, instr_count=0, cycle_count=0.

Source files
------------

// File: rtl/cpu_state_sequencer.sv
// Multicycle state generator for the Avalon-bus MIPS core: FETCH/DECODE/EXEC1/EXEC2/HALT
// with waitrequest holds, stall watchdog and retire counter. Optional SEQ_PERF_COUNTERS_EN adds cycle/stall counters.
//
// state  | meaning
// HALT   | stopped after jump to 0, watchdog expiry or illegal code; left only by reset
// FETCH  | instruction read on Avalon; held while waitrequest
// DECODE | single-cycle decode
// EXEC1  | execute / load; held while mem_read & waitrequest
// EXEC2  | writeback / store; held while mem_write & waitrequest, retires instruction
module cpu_state_sequencer #(
  parameter int STALL_LIMIT = 1024,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               waitrequest,
  input  logic [31:0]        pc_next,
  output logic [3:0]         state,
  output logic               active,
  output logic               stalled,
  output logic [COUNT_W-1:0] instr_count,
  output logic               timeout,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] stall_count
);

  typedef enum logic [3:0] {
    S_HALT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC1  = 4'd3,
    S_EXEC2  = 4'd4
  } state_t;

  // Timer never needs to exceed STALL_LIMIT: reaching it while stalled halts the core.
  localparam int TW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

  state_t          state_q, state_d;
  logic [TW-1:0]   stall_timer;
  logic            wd_hit;
  logic            retire;

  assign state  = state_q;
  assign active = (state_q != S_HALT);

  always_comb begin
    stalled = 1'b0;
    case (state_q)
      S_FETCH: stalled = waitrequest;
      S_EXEC1: stalled = mem_read & waitrequest;
      S_EXEC2: stalled = mem_write & waitrequest;
      default: stalled = 1'b0;
    endcase
  end

  assign wd_hit = (STALL_LIMIT > 0) && stalled && (stall_timer == TW'(STALL_LIMIT));

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_HALT:   state_d = S_HALT;
      S_FETCH:  if (!waitrequest) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1:  if (!(mem_read && waitrequest)) state_d = S_EXEC2;
      S_EXEC2: begin
        if (!(mem_write && waitrequest)) begin
          retire  = 1'b1;
          state_d = (pc_next == 32'h0000_0000) ? S_HALT : S_FETCH;
        end
      end
      default:  state_d = S_HALT;
    endcase
    // A stalled cycle never retires, so the watchdog cannot collide with a retire.
    if (wd_hit) state_d = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      instr_count <= '0;
      timeout     <= 1'b0;
      stall_timer <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + 1'b1;
      if (wd_hit) timeout <= 1'b1;
      stall_timer <= stalled ? stall_timer + 1'b1 : '0;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (state_q != S_HALT) cycle_count <= cycle_count + 1'b1;
      if (stalled)           stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign cycle_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed bench for cpu_state_sequencer (STALL_LIMIT=4); perf-counter expectations
// follow SEQ_PERF_COUNTERS_EN.
module tb_cpu_state_sequencer;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          waitrequest = 1'b0;
  logic [31:0]   pc_next = 32'h0000_1000;
  logic [3:0]    state;
  logic          active;
  logic          stalled;
  logic [CW-1:0] instr_count;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] stall_count;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_state_sequencer #(.STALL_LIMIT(4), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .waitrequest(waitrequest), .pc_next(pc_next), .state(state), .active(active),
    .stalled(stalled), .instr_count(instr_count), .timeout(timeout),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] cyc, input logic [31:0] stl);
`ifdef SEQ_PERF_COUNTERS_EN
    chk({tag, "_cycle"}, cycle_count, cyc);
    chk({tag, "_stall"}, stall_count, stl);
`else
    chk({tag, "_cycle"}, cycle_count, 32'd0);
    chk({tag, "_stall"}, stall_count, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_state", state, 4'd1);
    chk("rst_active", active, 1'b1);
    chk("rst_instr", instr_count, 0);
    chk("rst_timeout", timeout, 1'b0);
    chk_perf("rst", 0, 0);

    // no-stall run
    reset = 1'b0;
    #1 chk("ns_stalled_f", stalled, 1'b0);
    tick(); chk("ns_state2", state, 4'd2); chk("ns_stalled_d", stalled, 1'b0);
    tick(); chk("ns_state3", state, 4'd3); chk("ns_stalled_e1", stalled, 1'b0);
    tick(); chk("ns_state4", state, 4'd4); chk("ns_stalled_e2", stalled, 1'b0);
    tick(); chk("ns_state1", state, 4'd1);
    chk("ns_instr", instr_count, 1);
    chk_perf("ns", 4, 0);

    // fetch stall, 3 cycles
    waitrequest = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fs_stalled", stalled, 1'b1);
      tick();
      chk("fs_hold", state, 4'd1);
    end
    waitrequest = 1'b0;
    #1 chk("fs_release_stalled", stalled, 1'b0);
    tick(); chk("fs_decode", state, 4'd2);
    chk_perf("fs", 8, 3);

    // lw stall in EXEC1; DECODE ignores the handshake
    mem_read = 1'b1; waitrequest = 1'b1;
    #1 chk("lw_decode_nostall", stalled, 1'b0);
    tick(); chk("lw_exec1", state, 4'd3); chk("lw_stalled", stalled, 1'b1);
    tick(); chk("lw_hold1", state, 4'd3);
    tick(); chk("lw_hold2", state, 4'd3);
    waitrequest = 1'b0;
    #1 chk("lw_release", stalled, 1'b0);
    tick(); chk("lw_exec2", state, 4'd4);
    mem_read = 1'b0;
    tick(); chk("lw_fetch", state, 4'd1);
    chk("lw_instr", instr_count, 2);
    chk_perf("lw", 13, 5);

    // write-only instruction: no hold in EXEC1, hold in EXEC2
    tick(); tick(); chk("sw_exec1", state, 4'd3);
    mem_write = 1'b1; waitrequest = 1'b1;
    #1 chk("sw_exec1_nostall", stalled, 1'b0);
    tick(); chk("sw_exec2", state, 4'd4); chk("sw_exec2_stalled", stalled, 1'b1);
    tick(); chk("sw_exec2_hold", state, 4'd4);
    chk("sw_instr_held", instr_count, 2);
    waitrequest = 1'b0;
    tick(); chk("sw_fetch", state, 4'd1);
    chk("sw_instr", instr_count, 3);
    mem_write = 1'b0;

    // halt on jump to zero
    tick(); tick(); tick(); chk("hz_exec2", state, 4'd4);
    pc_next = 32'h0;
    tick();
    chk("hz_state", state, 4'd0);
    chk("hz_active", active, 1'b0);
    chk("hz_instr", instr_count, 4);
    chk("hz_timeout", timeout, 1'b0);
    chk_perf("hz", 22, 6);
    mem_read = 1'b1; mem_write = 1'b1; waitrequest = 1'b1; pc_next = 32'h0000_1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hz_stay", state, 4'd0);
      chk("hz_stay_stalled", stalled, 1'b0);
    end
    chk("hz_instr_frozen", instr_count, 4);
    chk_perf("hz_frozen", 22, 6);

    // watchdog: 5th consecutive stalled FETCH cycle halts
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    tick();
    reset = 1'b0;
    chk("wd_start", state, 4'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("wd_before", state, 4'd1);
    chk("wd_before_to", timeout, 1'b0);
    tick();
    chk("wd_halt", state, 4'd0);
    chk("wd_timeout", timeout, 1'b1);
    chk_perf("wd", 5, 5);
    tick();
    chk("wd_sticky", timeout, 1'b1);
    reset = 1'b1; waitrequest = 1'b0;
    tick();
    chk("wd_rst_state", state, 4'd1);
    chk("wd_rst_timeout", timeout, 1'b0);
    chk("wd_rst_instr", instr_count, 0);
    chk_perf("wd_rst", 0, 0);
    reset = 1'b0;

    // reset during a stalled EXEC2
    tick(); tick(); tick(); tick();
    chk("rm_instr1", instr_count, 1);
    tick(); tick();
    mem_write = 1'b1; waitrequest = 1'b1;
    tick(); chk("rm_exec2", state, 4'd4);
    tick(); chk("rm_hold", state, 4'd4); chk("rm_stalled", stalled, 1'b1);
    reset = 1'b1;
    tick();
    chk("rm_state", state, 4'd1);
    chk("rm_instr", instr_count, 0);
    chk("rm_timeout", timeout, 1'b0);
    chk_perf("rm", 0, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
